run_loader: RTL
===============

Name: run_loader

Overview:
- Host-side sequencer directly upstream of the processor top level.
- Streams a byte image from the host into data memory while the processor is held in reset.
- Then releases the processor, pulses `req`, and waits for `done` or a timeout.
- Then streams a result window of data memory back to the host.
- Owns the processor's reset/req/done handshake and the data-memory port while the processor is not running.

Parameters:
- AW, 8, data-memory address width
- LD_BASE, 0, first memory address written during load
- LD_LEN, 64, bytes accepted per load (≥1)
- RD_BASE, 64, first memory address read during drain
- RD_LEN, 32, bytes returned per drain (≥1)
- TIMEOUT, 4096, max cycles in RUN before abort (≥1)
- TW, 16, timeout counter width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  host load byte valid
- in_data  in  8  host load byte
- in_ready  out  1  load byte accepted when in_valid&in_ready
- out_valid  out  1  result byte valid (registered)
- out_data  out  8  result byte (registered)
- out_ready  in  1  host accepts result byte
- mem_wr_en  out  1  data-memory write enable
- mem_addr  out  AW  data-memory address
- mem_wdata  out  8  data-memory write data
- mem_rdata  in  8  data-memory read data, combinational from mem_addr
- cpu_reset  out  1  holds processor in reset when 1
- cpu_req  out  1  one-cycle start pulse to processor
- cpu_done  in  1  processor done
- busy  out  1  state ≠ IDLE
- err_timeout  out  1  last run hit TIMEOUT

Behaviour:
- Reset values: state=IDLE; counters=0; out_valid=0; out_data=0; cpu_reset=1; cpu_req=0; err_timeout=0; mem_wr_en=0.
- States: IDLE, LOAD, START, RUN, DRAIN.

IDLE:
- in_ready=1.
- An accepted byte writes LD_BASE, sets ld_cnt=1, clears err_timeout, and moves to LOAD.
- If LD_LEN==1, it moves to START instead.

LOAD:
- in_ready=1.
- Each accepted byte writes LD_BASE+ld_cnt (mod 2^AW) and increments ld_cnt.
- The byte that makes ld_cnt==LD_LEN moves the FSM to START.
- Memory write is same-cycle: mem_wr_en=in_valid&in_ready, mem_wdata=in_data.

Handshake rules:
- in_ready=0 in START, RUN and DRAIN; in_valid is ignored there.
- in_valid with in_ready low writes nothing.

START (exactly 1 cycle):
- cpu_reset=0, cpu_req=1, then RUN.

RUN:
- cpu_reset=0, cpu_req=0; run counter increments every cycle.
- cpu_done is sampled in RUN only; a done level seen during START is ignored.
- cpu_done=1 moves to DRAIN with err_timeout unchanged (0).
- Counter reaching TIMEOUT without done sets err_timeout=1 and moves to DRAIN.
- If done and timeout occur in the same cycle, done wins (err_timeout stays 0).

DRAIN:
- cpu_reset=1 from the first DRAIN cycle; mem_wr_en=0; mem_addr=RD_BASE+rd_cnt (mod 2^AW).
- Output register loads when out_valid==0 or out_ready==1: out_data<=mem_rdata, out_valid<=1, rd_cnt++.
- While out_valid&!out_ready, out_data and out_valid hold stable.
- After RD_LEN bytes are loaded, no further loads occur.
- When the last byte is accepted (out_valid&out_ready and rd_cnt==RD_LEN), out_valid<=0 and the FSM goes to IDLE.

Memory address mux:
- mem_addr follows the load address in IDLE/LOAD, the read address in DRAIN, and is 0 in START/RUN.
- The processor owns memory in START/RUN; this block drives mem_wr_en=0 there.

Reset mid-operation:
- Reset is async in any state.
- Returns to IDLE with cpu_reset=1 and drops any partial load/drain; there is no resume.

Latency:
- First out_valid appears 1 cycle after DRAIN entry.
- With out_ready held high, throughput is 1 byte/cycle.

Optional Feature:
- Macro: RUN_LOADER_CHKSUM_EN.
- Defined: after the RD_LEN data bytes, one extra byte is emitted: the 8-bit sum mod 256 of all drained data bytes, with the same valid/ready rules. IDLE is entered when the checksum byte is accepted.
- Undefined: exactly RD_LEN bytes; no accumulator logic.

Test Plan (bench params LD_BASE=0, LD_LEN=4, RD_BASE=64, RD_LEN=2, TIMEOUT=16):
- Normal run:
  - Stimulus: load bytes 11,22,33,44 back-to-back; model writes mem[64]=AA, mem[65]=BB; cpu_done rises 5 cycles after cpu_req.
  - Response: writes to addr 0..3; one cpu_req pulse; out stream AA,BB; busy=0 afterwards; err_timeout=0.
- Host backpressure on load:
  - Stimulus: in_valid toggles 1,0,1,0 between bytes.
  - Response: exactly 4 writes, addresses 0..3, no duplicates; START entered only after the 4th byte.
- Backpressure on drain:
  - Stimulus: out_ready=0 for 3 cycles after out_valid rises.
  - Response: out_data holds AA stable; BB follows the first accepted beat; no byte is lost or duplicated.
- Timeout:
  - Stimulus: cpu_done never asserted.
  - Response: DRAIN entered 16 cycles after RUN entry; err_timeout=1; cpu_reset=1; data still drained.
  - Follow-up: the next load byte clears err_timeout.
- Done and timeout in the same cycle:
  - Stimulus: cpu_done asserted on the 16th RUN cycle.
  - Response: err_timeout=0.
- Async reset mid-DRAIN:
  - Stimulus: assert reset between output beats.
  - Response: immediately out_valid=0, cpu_reset=1, busy=0.
  - Follow-up: a fresh 4-byte load restarts from address 0.
- Checksum (macro defined):
  - Stimulus: normal run with drained bytes AA,BB.
  - Response: third output byte is 65 (AA+BB mod 256).

Source files
------------

// File: rtl/run_loader.sv
// run_loader: host load -> processor run -> result drain sequencer.
// Defining RUN_LOADER_CHKSUM_EN appends a mod-256 checksum byte to each drain.
module run_loader #(
  parameter int AW      = 8,
  parameter int LD_BASE = 0,
  parameter int LD_LEN  = 64,
  parameter int RD_BASE = 64,
  parameter int RD_LEN  = 32,
  parameter int TIMEOUT = 4096,
  parameter int TW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [7:0]    out_data,
  input  logic          out_ready,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic          cpu_reset,
  output logic          cpu_req,
  input  logic          cpu_done,
  output logic          busy,
  output logic          err_timeout
);
  localparam int LW = $clog2(LD_LEN + 1);
`ifdef RUN_LOADER_CHKSUM_EN
  localparam int NB = RD_LEN + 1;
`else
  localparam int NB = RD_LEN;
`endif
  localparam int RW = $clog2(NB + 1);
  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DRAIN} state_t;
  state_t          r_state;
  logic [LW-1:0]   r_ld_cnt;
  logic [RW-1:0]   r_rd_cnt;
  logic [TW-1:0]   r_run_cnt;
  logic            r_out_valid, r_cpu_reset, r_cpu_req, r_err;
  logic [7:0]      r_out_data;
  logic            w_load_phase, w_acc, w_pull, w_last;
  logic [7:0]      w_byte;
  assign w_load_phase = r_state == IDLE || r_state == LOAD;
  assign w_acc        = in_valid & w_load_phase;
  assign w_pull       = r_state == DRAIN && (!r_out_valid || out_ready) && r_rd_cnt != RW'(NB);
  assign w_last       = r_out_valid && out_ready && r_rd_cnt == RW'(NB);
  assign in_ready     = w_load_phase;
  assign mem_wr_en    = w_acc;
  assign mem_wdata    = in_data;
  assign mem_addr     = w_load_phase ? AW'(LD_BASE) + AW'(r_ld_cnt) :
                        r_state == DRAIN ? AW'(RD_BASE) + AW'(r_rd_cnt) : '0;
  assign busy         = r_state != IDLE;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign cpu_reset    = r_cpu_reset;
  assign cpu_req      = r_cpu_req;
  assign err_timeout  = r_err;
`ifdef RUN_LOADER_CHKSUM_EN
  logic [7:0] r_sum;
  // the beat after the last data byte carries the running sum instead of memory
  assign w_byte = r_rd_cnt == RW'(RD_LEN) ? r_sum : mem_rdata;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sum <= '0;
    else if (r_state != DRAIN) r_sum <= '0;
    else if (w_pull) r_sum <= r_sum + mem_rdata;
  end
`else
  assign w_byte = mem_rdata;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ld_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_run_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_cpu_reset <= 1'b1;
      r_cpu_req   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_cpu_req <= 1'b0;
      case (r_state)
        IDLE, LOAD: if (w_acc) begin
          if (r_state == IDLE) r_err <= 1'b0;
          if (r_ld_cnt == LW'(LD_LEN - 1)) begin
            r_ld_cnt    <= '0;
            r_run_cnt   <= '0;
            r_cpu_reset <= 1'b0;
            r_cpu_req   <= 1'b1;
            r_state     <= START;
          end else begin
            r_ld_cnt <= r_ld_cnt + LW'(1);
            r_state  <= LOAD;
          end
        end
        START: r_state <= RUN;
        // done takes priority over a timeout landing in the same cycle
        RUN: if (cpu_done || r_run_cnt == TW'(TIMEOUT - 1)) begin
          r_err       <= !cpu_done;
          r_cpu_reset <= 1'b1;
          r_rd_cnt    <= '0;
          r_state     <= DRAIN;
        end else r_run_cnt <= r_run_cnt + TW'(1);
        DRAIN: if (w_last) begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end else if (w_pull) begin
          r_out_data  <= w_byte;
          r_out_valid <= 1'b1;
          r_rd_cnt    <= r_rd_cnt + RW'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
